// File: rtl/opcodec.sv
// M6502 instruction decoder: one registered stage turning an opcode byte into
// operation, addressing mode, access type and index register.
package M6502Defs;

    typedef enum logic [5:0] {
        ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI,
        BNE, BPL, BRK, BVC, BVS, CLC, CLD, CLI,
        CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR,
        INC, INX, INY, JMP, JSR, LDA, LDX, LDY,
        LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL,
        ROR, RTI, RTS, SBC, SEC, SED, SEI, STA,
        STX, STY, TAX, TAY, TSX, TXA, TXS, TYA
    } Operation;

    typedef enum logic [3:0] {
        Implied,
        Immediate,
        ZeroPage,
        ZeroPageIndexed,
        Absolute,
        AbsoluteIndexed,
        AbsoluteIndirect,
        IndexedIndirect,
        IndirectIndexed,
        Relative
    } AddressingMode;

    typedef enum logic [1:0] {
        Access_Read,
        Access_Write,
        Access_ReadWrite
    } AccessType;

    typedef enum logic [1:0] {
        Index_None,
        Index_X,
        Index_Y
    } Index;

    typedef struct packed {
        Operation      op;
        AddressingMode mode;
        AccessType     acc;
        Index          idx;
    } Decode_t;

    localparam Decode_t DECODE_NOP = '{op: NOP, mode: Implied, acc: Access_Read, idx: Index_None};

endpackage

module opcodec
    import M6502Defs::*;
(
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic [7:0]    i_opcode,
    output Operation      o_operation,
    output AddressingMode o_addressingMode,
    output AccessType     o_accessType,
    output Index          o_index
);

    logic [2:0] w_aaa;
    logic [2:0] w_bbb;
    logic [1:0] w_cc;
    Decode_t    w_decode;
    Decode_t    r_decode;

    assign w_aaa = i_opcode[7:5];
    assign w_bbb = i_opcode[4:2];
    assign w_cc  = i_opcode[1:0];

    function automatic Decode_t makeDecode(input Operation op, input AddressingMode mode,
                                           input AccessType acc, input Index idx);
        Decode_t d;
        d.op   = op;
        d.mode = mode;
        d.acc  = acc;
        d.idx  = idx;
        return d;
    endfunction

    function automatic Operation aluOp(input logic [2:0] aaa);
        Operation op;
        case (aaa)
            3'd0:    op = ORA;
            3'd1:    op = AND;
            3'd2:    op = EOR;
            3'd3:    op = ADC;
            3'd4:    op = STA;
            3'd5:    op = LDA;
            3'd6:    op = CMP;
            default: op = SBC;
        endcase
        return op;
    endfunction

    function automatic Operation rmwOp(input logic [2:0] aaa);
        Operation op;
        case (aaa)
            3'd0:    op = ASL;
            3'd1:    op = ROL;
            3'd2:    op = LSR;
            3'd3:    op = ROR;
            3'd4:    op = STX;
            3'd5:    op = LDX;
            3'd6:    op = DEC;
            default: op = INC;
        endcase
        return op;
    endfunction

    // cc=01 and most of cc=10 decode from the bit fields; cc=00 is too irregular
    // and is looked up by full opcode instead.
    always_comb begin
        w_decode = DECODE_NOP;
        case (w_cc)
            2'b01: begin
                if (i_opcode != 8'h89) begin
                    w_decode.op  = aluOp(w_aaa);
                    w_decode.acc = (w_aaa == 3'd4) ? Access_Write : Access_Read;
                    case (w_bbb)
                        3'b000: begin
                            w_decode.mode = IndexedIndirect;
                            w_decode.idx  = Index_X;
                        end
                        3'b001: w_decode.mode = ZeroPage;
                        3'b010: w_decode.mode = Immediate;
                        3'b011: w_decode.mode = Absolute;
                        3'b100: begin
                            w_decode.mode = IndirectIndexed;
                            w_decode.idx  = Index_Y;
                        end
                        3'b101: begin
                            w_decode.mode = ZeroPageIndexed;
                            w_decode.idx  = Index_X;
                        end
                        3'b110: begin
                            w_decode.mode = AbsoluteIndexed;
                            w_decode.idx  = Index_Y;
                        end
                        default: begin
                            w_decode.mode = AbsoluteIndexed;
                            w_decode.idx  = Index_X;
                        end
                    endcase
                end
            end
            2'b10: begin
                case (w_bbb)
                    3'b000: begin
                        if (w_aaa == 3'd5)
                            w_decode = makeDecode(LDX, Immediate, Access_Read, Index_None);
                    end
                    3'b001, 3'b011, 3'b101, 3'b111: begin
                        // STX has no absolute-indexed form (9E)
                        if (!(w_aaa == 3'd4 && w_bbb == 3'b111)) begin
                            w_decode.op = rmwOp(w_aaa);
                            if (w_bbb[2])
                                w_decode.mode = w_bbb[1] ? AbsoluteIndexed : ZeroPageIndexed;
                            else
                                w_decode.mode = w_bbb[1] ? Absolute : ZeroPage;
                            if (w_bbb[2])
                                w_decode.idx = (w_aaa == 3'd4 || w_aaa == 3'd5) ? Index_Y : Index_X;
                            else
                                w_decode.idx = Index_None;
                            case (w_aaa)
                                3'd4:    w_decode.acc = Access_Write;
                                3'd5:    w_decode.acc = Access_Read;
                                default: w_decode.acc = Access_ReadWrite;
                            endcase
                        end
                    end
                    3'b010: begin
                        case (w_aaa)
                            3'd4:    w_decode.op = TXA;
                            3'd5:    w_decode.op = TAX;
                            3'd6:    w_decode.op = DEX;
                            3'd7:    w_decode.op = NOP;
                            default: w_decode.op = rmwOp(w_aaa);
                        endcase
                    end
                    3'b110: begin
                        if (w_aaa == 3'd4)
                            w_decode.op = TXS;
                        else if (w_aaa == 3'd5)
                            w_decode.op = TSX;
                    end
                    default: ;
                endcase
            end
            2'b00: begin
                case (i_opcode)
                    8'h24: w_decode = makeDecode(BIT, ZeroPage,         Access_Read,  Index_None);
                    8'h2C: w_decode = makeDecode(BIT, Absolute,         Access_Read,  Index_None);
                    8'h4C: w_decode = makeDecode(JMP, Absolute,         Access_Read,  Index_None);
                    8'h6C: w_decode = makeDecode(JMP, AbsoluteIndirect, Access_Read,  Index_None);
                    8'h20: w_decode = makeDecode(JSR, Absolute,         Access_Read,  Index_None);
                    8'h84: w_decode = makeDecode(STY, ZeroPage,         Access_Write, Index_None);
                    8'h94: w_decode = makeDecode(STY, ZeroPageIndexed,  Access_Write, Index_X);
                    8'h8C: w_decode = makeDecode(STY, Absolute,         Access_Write, Index_None);
                    8'hA0: w_decode = makeDecode(LDY, Immediate,        Access_Read,  Index_None);
                    8'hA4: w_decode = makeDecode(LDY, ZeroPage,         Access_Read,  Index_None);
                    8'hB4: w_decode = makeDecode(LDY, ZeroPageIndexed,  Access_Read,  Index_X);
                    8'hAC: w_decode = makeDecode(LDY, Absolute,         Access_Read,  Index_None);
                    8'hBC: w_decode = makeDecode(LDY, AbsoluteIndexed,  Access_Read,  Index_X);
                    8'hC0: w_decode = makeDecode(CPY, Immediate,        Access_Read,  Index_None);
                    8'hC4: w_decode = makeDecode(CPY, ZeroPage,         Access_Read,  Index_None);
                    8'hCC: w_decode = makeDecode(CPY, Absolute,         Access_Read,  Index_None);
                    8'hE0: w_decode = makeDecode(CPX, Immediate,        Access_Read,  Index_None);
                    8'hE4: w_decode = makeDecode(CPX, ZeroPage,         Access_Read,  Index_None);
                    8'hEC: w_decode = makeDecode(CPX, Absolute,         Access_Read,  Index_None);
                    8'h10: w_decode = makeDecode(BPL, Relative,         Access_Read,  Index_None);
                    8'h30: w_decode = makeDecode(BMI, Relative,         Access_Read,  Index_None);
                    8'h50: w_decode = makeDecode(BVC, Relative,         Access_Read,  Index_None);
                    8'h70: w_decode = makeDecode(BVS, Relative,         Access_Read,  Index_None);
                    8'h90: w_decode = makeDecode(BCC, Relative,         Access_Read,  Index_None);
                    8'hB0: w_decode = makeDecode(BCS, Relative,         Access_Read,  Index_None);
                    8'hD0: w_decode = makeDecode(BNE, Relative,         Access_Read,  Index_None);
                    8'hF0: w_decode = makeDecode(BEQ, Relative,         Access_Read,  Index_None);
                    8'h00: w_decode.op = BRK;
                    8'h40: w_decode.op = RTI;
                    8'h60: w_decode.op = RTS;
                    8'h08: w_decode = makeDecode(PHP, Implied,          Access_Write, Index_None);
                    8'h28: w_decode.op = PLP;
                    8'h48: w_decode = makeDecode(PHA, Implied,          Access_Write, Index_None);
                    8'h68: w_decode.op = PLA;
                    8'h88: w_decode.op = DEY;
                    8'hA8: w_decode.op = TAY;
                    8'hC8: w_decode.op = INY;
                    8'hE8: w_decode.op = INX;
                    8'h18: w_decode.op = CLC;
                    8'h38: w_decode.op = SEC;
                    8'h58: w_decode.op = CLI;
                    8'h78: w_decode.op = SEI;
                    8'h98: w_decode.op = TYA;
                    8'hB8: w_decode.op = CLV;
                    8'hD8: w_decode.op = CLD;
                    8'hF8: w_decode.op = SED;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_decode <= DECODE_NOP;
        else
            r_decode <= w_decode;
    end

    assign o_operation      = r_decode.op;
    assign o_addressingMode = r_decode.mode;
    assign o_accessType     = r_decode.acc;
    assign o_index          = r_decode.idx;

endmodule

// File: tb/tb_opcodec.sv
// Scoreboard bench for opcodec: a table-driven opcode model feeds expected
// decodes into a queue that a monitor drains one cycle after each issue.
module tb_opcodec;
    import M6502Defs::*;

    logic          clk = 1'b0;
    logic          resetN;
    logic [7:0]    opcode;
    Operation      operation;
    AddressingMode addressingMode;
    AccessType     accessType;
    Index          index;

    always #5 clk = ~clk;

    opcodec dut (
        .i_clk            (clk),
        .i_reset_n        (resetN),
        .i_opcode         (opcode),
        .o_operation      (operation),
        .o_addressingMode (addressingMode),
        .o_accessType     (accessType),
        .o_index          (index)
    );

    typedef struct {
        logic [7:0]    code;
        Operation      op;
        AddressingMode mode;
        AccessType     acc;
        Index          idx;
    } ExpT;

    ExpT           scoreboard[$];
    Operation      mOp[256];
    AddressingMode mMode[256];
    AccessType     mAcc[256];
    Index          mIdx[256];
    bit            mOfficial[256];
    int            checkCount = 0;
    int            passCount  = 0;

    // Access type follows from what the instruction does to memory.
    function automatic AccessType accessRule(input Operation op, input AddressingMode mode);
        if (op == STA || op == STX || op == STY || op == PHA || op == PHP)
            return Access_Write;
        if ((op == ASL || op == LSR || op == ROL || op == ROR || op == INC || op == DEC) && mode != Implied)
            return Access_ReadWrite;
        return Access_Read;
    endfunction

    task automatic addOp(input logic [7:0] code, input Operation op, input AddressingMode mode, input Index idx);
        mOp[code]       = op;
        mMode[code]     = mode;
        mAcc[code]      = accessRule(op, mode);
        mIdx[code]      = idx;
        mOfficial[code] = 1'b1;
    endtask

    task automatic buildModel();
        Operation      ops01[8]  = '{ORA, AND, EOR, ADC, STA, LDA, CMP, SBC};
        AddressingMode mode01[8] = '{IndexedIndirect, ZeroPage, Immediate, Absolute,
                                     IndirectIndexed, ZeroPageIndexed, AbsoluteIndexed, AbsoluteIndexed};
        Index          idx01[8]  = '{Index_X, Index_None, Index_None, Index_None,
                                     Index_Y, Index_X, Index_Y, Index_X};
        Operation      ops10[8]  = '{ASL, ROL, LSR, ROR, STX, LDX, DEC, INC};
        AddressingMode mode10[4] = '{ZeroPage, Absolute, ZeroPageIndexed, AbsoluteIndexed};
        logic [7:0]    c;
        Index          ix;
        for (int i = 0; i < 256; i++) begin
            mOp[i] = NOP; mMode[i] = Implied; mAcc[i] = Access_Read; mIdx[i] = Index_None;
            mOfficial[i] = 1'b0;
        end
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++) begin
                c = {3'(a), 3'(b), 2'b01};
                if (c != 8'h89) addOp(c, ops01[a], mode01[b], idx01[b]);
            end
        for (int a = 0; a < 8; a++)
            for (int m = 0; m < 4; m++) begin
                c = {3'(a), 3'(2 * m + 1), 2'b10};
                ix = (m < 2) ? Index_None : ((ops10[a] == STX || ops10[a] == LDX) ? Index_Y : Index_X);
                if (c != 8'h9E) addOp(c, ops10[a], mode10[m], ix);
            end
        addOp(8'hA2, LDX, Immediate, Index_None);
        addOp(8'h0A, ASL, Implied, Index_None); addOp(8'h2A, ROL, Implied, Index_None);
        addOp(8'h4A, LSR, Implied, Index_None); addOp(8'h6A, ROR, Implied, Index_None);
        addOp(8'h8A, TXA, Implied, Index_None); addOp(8'h9A, TXS, Implied, Index_None);
        addOp(8'hAA, TAX, Implied, Index_None); addOp(8'hBA, TSX, Implied, Index_None);
        addOp(8'hCA, DEX, Implied, Index_None); addOp(8'hEA, NOP, Implied, Index_None);
        addOp(8'h24, BIT, ZeroPage, Index_None); addOp(8'h2C, BIT, Absolute, Index_None);
        addOp(8'h4C, JMP, Absolute, Index_None); addOp(8'h6C, JMP, AbsoluteIndirect, Index_None);
        addOp(8'h20, JSR, Absolute, Index_None);
        addOp(8'h84, STY, ZeroPage, Index_None); addOp(8'h94, STY, ZeroPageIndexed, Index_X);
        addOp(8'h8C, STY, Absolute, Index_None);
        addOp(8'hA0, LDY, Immediate, Index_None); addOp(8'hA4, LDY, ZeroPage, Index_None);
        addOp(8'hB4, LDY, ZeroPageIndexed, Index_X); addOp(8'hAC, LDY, Absolute, Index_None);
        addOp(8'hBC, LDY, AbsoluteIndexed, Index_X);
        addOp(8'hC0, CPY, Immediate, Index_None); addOp(8'hC4, CPY, ZeroPage, Index_None);
        addOp(8'hCC, CPY, Absolute, Index_None);
        addOp(8'hE0, CPX, Immediate, Index_None); addOp(8'hE4, CPX, ZeroPage, Index_None);
        addOp(8'hEC, CPX, Absolute, Index_None);
        addOp(8'h10, BPL, Relative, Index_None); addOp(8'h30, BMI, Relative, Index_None);
        addOp(8'h50, BVC, Relative, Index_None); addOp(8'h70, BVS, Relative, Index_None);
        addOp(8'h90, BCC, Relative, Index_None); addOp(8'hB0, BCS, Relative, Index_None);
        addOp(8'hD0, BNE, Relative, Index_None); addOp(8'hF0, BEQ, Relative, Index_None);
        addOp(8'h00, BRK, Implied, Index_None); addOp(8'h40, RTI, Implied, Index_None);
        addOp(8'h60, RTS, Implied, Index_None); addOp(8'h08, PHP, Implied, Index_None);
        addOp(8'h28, PLP, Implied, Index_None); addOp(8'h48, PHA, Implied, Index_None);
        addOp(8'h68, PLA, Implied, Index_None); addOp(8'h88, DEY, Implied, Index_None);
        addOp(8'hA8, TAY, Implied, Index_None); addOp(8'hC8, INY, Implied, Index_None);
        addOp(8'hE8, INX, Implied, Index_None); addOp(8'h18, CLC, Implied, Index_None);
        addOp(8'h38, SEC, Implied, Index_None); addOp(8'h58, CLI, Implied, Index_None);
        addOp(8'h78, SEI, Implied, Index_None); addOp(8'h98, TYA, Implied, Index_None);
        addOp(8'hB8, CLV, Implied, Index_None); addOp(8'hD8, CLD, Implied, Index_None);
        addOp(8'hF8, SED, Implied, Index_None);
    endtask

    function automatic ExpT expected(input logic [7:0] code);
        ExpT e;
        e.code = code; e.op = mOp[code]; e.mode = mMode[code]; e.acc = mAcc[code]; e.idx = mIdx[code];
        return e;
    endfunction

    function automatic ExpT nopExpected(input logic [7:0] code);
        ExpT e;
        e.code = code; e.op = NOP; e.mode = Implied; e.acc = Access_Read; e.idx = Index_None;
        return e;
    endfunction

    task automatic checkOutput(input string name, input ExpT e);
        checkCount++;
        if (operation == e.op && addressingMode == e.mode && accessType == e.acc && index == e.idx)
            passCount++;
        else
            $display("[TB] FAIL %s opcode %02h: got {%s,%s,%s,%s} required {%s,%s,%s,%s}",
                     name, e.code, operation.name(), addressingMode.name(), accessType.name(), index.name(),
                     e.op.name(), e.mode.name(), e.acc.name(), e.idx.name());
    endtask

    task automatic applyStimulus(input logic [7:0] code);
        @(negedge clk);
        opcode = code;
        scoreboard.push_back(expected(code));
    endtask

    // Every issued opcode becomes visible one rising edge later.
    initial begin
        ExpT e;
        forever begin
            @(posedge clk);
            #1;
            if (resetN && scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checkOutput("decode", e);
            end
        end
    end

    initial begin
        logic [7:0] illegal[5] = '{8'h89, 8'h9E, 8'h02, 8'hFF, 8'h1A};
        buildModel();
        resetN = 1'b0;
        opcode = 8'h69;
        #12;
        checkOutput("reset_hold", nopExpected(8'h69));

        @(negedge clk);
        resetN = 1'b1;
        opcode = 8'h69;
        scoreboard.push_back(expected(8'h69));

        for (int i = 0; i < 256; i++)
            if (mOfficial[i]) applyStimulus(8'(i));
        foreach (illegal[i]) applyStimulus(illegal[i]);
        repeat (200) applyStimulus(8'($urandom_range(0, 255)));

        applyStimulus(8'hD0);
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("reset_mid", nopExpected(8'hD0));
        @(negedge clk);
        resetN = 1'b1;
        opcode = 8'hD0;
        scoreboard.push_back(expected(8'hD0));

        for (int i = 0; i < 50 && scoreboard.size() > 0; i++) @(posedge clk);
        #2;
        if (scoreboard.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d decodes still pending, required 0", scoreboard.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
